// File: rtl/control_sequencer.sv
// Multi-cycle phase sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB. It turns the decoder's control word into
// per-phase strobes, handles memory wait-states and timeout, traps
// illegal control words, and counts retired instructions.
module control_sequencer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             reg_dst,
   input  logic             alu_src,
   input  logic             mem_to_reg,
   input  logic             reg_write,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             branch,
   input  logic [1:0]       alu_op,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             pc_inc,
   output logic             pc_branch,
   output logic             alu_en,
   output logic [1:0]       alu_op_out,
   output logic             rf_we,
   output logic             rf_dst_sel,
   output logic             wb_sel,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
   } state_t;

   // Last wait count that may still be followed by a retry; a miss here traps.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [7:0]       wait_cnt;
   logic             retire;

   // alu_src steers the datapath operand mux directly; the sequencer ignores it.
   logic             cw_unused;
   assign cw_unused = alu_src;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Memory wait counter: runs while a FETCH/MEM access is stalled, zero otherwise,
   // so every fresh entry into FETCH or MEM starts from 0.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEM) && !mem_ready)
         wait_cnt <= wait_cnt + 8'd1;
      else
         wait_cnt <= '0;
   end

   // Retired-instruction counter, wraps naturally; frozen in ERR since retire is 0 there.
   always_ff @(posedge clk) begin
      if (rst)         retired <= '0;
      else if (retire) retired <= retired + CNT_W'(1);
   end

   // Next-state and per-phase strobe decode.
   always_comb begin
      state_nxt    = state;
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_inc       = 1'b0;
      pc_branch    = 1'b0;
      alu_en       = 1'b0;
      alu_op_out   = 2'b00;
      rf_we        = 1'b0;
      rf_dst_sel   = 1'b0;
      wb_sel       = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      busy         = (state != S_IDLE) && (state != S_ERR);

      unique case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_inc    = 1'b1;
               state_nxt = S_DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = S_ERR;
            end
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            alu_en     = 1'b1;
            alu_op_out = alu_op;
            if (mem_read && mem_write) begin
               state_nxt = S_ERR;
            end else if (branch) begin
               pc_branch = alu_zero;
               retire    = 1'b1;
            end else if (mem_read || mem_write) begin
               state_nxt = S_MEM;
            end else if (reg_write) begin
               state_nxt = S_WB;
            end else begin
               retire = 1'b1;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = mem_write;
            if (mem_ready) begin
               if (mem_read) state_nxt = S_WB;
               else          retire    = 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = S_ERR;
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            rf_dst_sel = reg_dst;
            wb_sel     = mem_to_reg;
            retire     = 1'b1;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: begin
            state_nxt = S_ERR;
         end
      endcase

      // Instruction boundary: the only place run is sampled after start.
      if (retire) begin
         done      = 1'b1;
         state_nxt = run ? S_FETCH : S_IDLE;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (TIMEOUT=4, CNT_W=2) with hand-computed
// per-cycle output vectors.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst, run;
   logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [1:0] alu_op;
   logic       alu_zero, mem_ready;
   logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_branch, alu_en;
   logic [1:0] alu_op_out;
   logic       rf_we, rf_dst_sel, wb_sel, busy, done, err;
   logic [1:0] retired;
   logic [14:0] outs;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [14:0] NONE = 15'h0000;
   localparam logic [14:0] REQ  = 15'h4000;
   localparam logic [14:0] WE   = 15'h2000;
   localparam logic [14:0] AS   = 15'h1000;
   localparam logic [14:0] IRW  = 15'h0800;
   localparam logic [14:0] PCI  = 15'h0400;
   localparam logic [14:0] PCB  = 15'h0200;
   localparam logic [14:0] ALU  = 15'h0100;
   localparam logic [14:0] OP10 = 15'h0080;
   localparam logic [14:0] OP01 = 15'h0040;
   localparam logic [14:0] RFW  = 15'h0020;
   localparam logic [14:0] DST  = 15'h0010;
   localparam logic [14:0] WBS  = 15'h0008;
   localparam logic [14:0] BSY  = 15'h0004;
   localparam logic [14:0] DN   = 15'h0002;
   localparam logic [14:0] ER   = 15'h0001;

   always #5 clk = ~clk;

   assign outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_inc, pc_branch, alu_en,
                  alu_op_out, rf_we, rf_dst_sel, wb_sel, busy, done, err};

   control_sequencer #(.TIMEOUT(4), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .run(run),
      .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .alu_op(alu_op), .alu_zero(alu_zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch), .alu_en(alu_en),
      .alu_op_out(alu_op_out), .rf_we(rf_we), .rf_dst_sel(rf_dst_sel), .wb_sel(wb_sel),
      .busy(busy), .done(done), .err(err), .retired(retired)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called 1 time unit after a rising edge with inputs already set for this cycle.
   task automatic cyc(input string tag, input logic [14:0] exp);
      #1;
      check(tag, 32'(outs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic set_cw(input logic rd, input logic as, input logic m2r, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic [1:0] op);
      reg_dst = rd; alu_src = as; mem_to_reg = m2r; reg_write = rw;
      mem_read = mr; mem_write = mw; branch = br; alu_op = op;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
      set_cw(0, 0, 0, 0, 0, 0, 0, 2'b00);
      @(posedge clk); #1;
      cyc("reset_outs", NONE);
      check("reset_retired", 32'(retired), 32'd0);

      // R-type, zero-wait memory.
      rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
      set_cw(1, 0, 0, 1, 0, 0, 0, 2'b10);
      cyc("r_idle", NONE);
      cyc("r_fetch", REQ | IRW | PCI | BSY);
      cyc("r_decode", BSY);
      cyc("r_exec", ALU | OP10 | BSY);
      cyc("r_wb", RFW | DST | BSY | DN);
      check("r_retired", 32'(retired), 32'd1);

      // lw with three MEM wait cycles; first cycle here is the FETCH following R-type.
      set_cw(0, 1, 1, 1, 1, 0, 0, 2'b00);
      cyc("lw_fetch", REQ | IRW | PCI | BSY);
      cyc("lw_decode", BSY);
      cyc("lw_exec", ALU | BSY);
      mem_ready = 1'b0;
      cyc("lw_mem_w1", REQ | AS | BSY);
      cyc("lw_mem_w2", REQ | AS | BSY);
      cyc("lw_mem_w3", REQ | AS | BSY);
      mem_ready = 1'b1;
      cyc("lw_mem_rdy", REQ | AS | BSY);
      cyc("lw_wb", RFW | WBS | BSY | DN);
      check("lw_retired", 32'(retired), 32'd2);

      // beq taken then not taken.
      set_cw(0, 0, 0, 0, 0, 0, 1, 2'b01);
      alu_zero = 1'b1;
      cyc("beq1_fetch", REQ | IRW | PCI | BSY);
      cyc("beq1_decode", BSY);
      cyc("beq1_exec", ALU | OP01 | PCB | BSY | DN);
      check("beq1_retired", 32'(retired), 32'd3);
      alu_zero = 1'b0;
      cyc("beq2_fetch", REQ | IRW | PCI | BSY);
      cyc("beq2_decode", BSY);
      cyc("beq2_exec", ALU | OP01 | BSY | DN);
      check("retired_wrap", 32'(retired), 32'd0);

      // sw with run dropped during MEM.
      set_cw(0, 1, 0, 0, 0, 1, 0, 2'b00);
      cyc("sw_fetch", REQ | IRW | PCI | BSY);
      cyc("sw_decode", BSY);
      cyc("sw_exec", ALU | BSY);
      run = 1'b0; mem_ready = 1'b0;
      cyc("sw_mem_wait", REQ | WE | AS | BSY);
      mem_ready = 1'b1;
      cyc("sw_mem_rdy", REQ | WE | AS | BSY | DN);
      cyc("sw_idle1", NONE);
      cyc("sw_idle2", NONE);
      check("sw_retired", 32'(retired), 32'd1);

      // FETCH timeout after four stalled cycles.
      set_cw(0, 0, 0, 0, 0, 0, 0, 2'b00);
      run = 1'b1; mem_ready = 1'b0;
      cyc("to_idle", NONE);
      cyc("to_fetch1", REQ | BSY);
      cyc("to_fetch2", REQ | BSY);
      cyc("to_fetch3", REQ | BSY);
      cyc("to_fetch4", REQ | BSY);
      cyc("to_err", ER);
      mem_ready = 1'b1;
      cyc("to_err_sticky", ER);
      check("to_retired", 32'(retired), 32'd1);
      rst = 1'b1; run = 1'b0;
      cyc("to_err_in_rst", ER);
      rst = 1'b0; run = 1'b1; mem_ready = 1'b0;
      check("rst_retired", 32'(retired), 32'd0);
      cyc("rst_idle", NONE);

      // Ready arrives on the last allowed wait cycle; then an all-zero NOP word.
      cyc("late_fetch1", REQ | BSY);
      cyc("late_fetch2", REQ | BSY);
      cyc("late_fetch3", REQ | BSY);
      mem_ready = 1'b1;
      cyc("late_fetch4", REQ | IRW | PCI | BSY);
      cyc("nop_decode", BSY);
      cyc("nop_exec", ALU | BSY | DN);
      check("nop_retired", 32'(retired), 32'd1);

      // Illegal word: mem_read and mem_write together.
      set_cw(0, 0, 0, 0, 1, 1, 0, 2'b00);
      cyc("ill_fetch", REQ | IRW | PCI | BSY);
      cyc("ill_decode", BSY);
      cyc("ill_exec", ALU | BSY);
      cyc("ill_err", ER);
      check("ill_retired", 32'(retired), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle phase sequencer on the consuming side of the opcode decoder's control word.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Turns the decoder's registered level signals (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op) into per-phase strobes for the PC, IR, ALU, register file and memory.
- Handles memory wait-states, a memory timeout, an illegal-control-word trap and a retired-instruction counter.

Parameters:
TIMEOUT, 16, maximum cycles spent waiting for mem_ready in FETCH or MEM before trapping to ERR (range 1..255).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  level; 1 = sequence instructions, 0 = stop at the next instruction boundary.
reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  in  1 each  decoder control word; valid from the DECODE cycle onward.
alu_op  in  2  decoder ALU class (00 add, 01 sub/compare, 10 funct-directed).
alu_zero  in  1  ALU zero flag; valid in EXEC.
mem_ready  in  1  memory completion; the access completes in the cycle mem_req=1 and mem_ready=1.
mem_req  out  1  memory request.
mem_we  out  1  write enable; valid only with mem_req.
mem_addr_sel  out  1  0 = PC (instruction), 1 = ALU result (data).
ir_write  out  1  load IR from memory read data.
pc_inc  out  1  PC <= PC+4.
pc_branch  out  1  PC <= branch target.
alu_en  out  1  ALU operate strobe.
alu_op_out  out  2  alu_op forwarded during EXEC, 00 otherwise.
rf_we  out  1  register-file write.
rf_dst_sel  out  1  reg_dst forwarded during WB, 0 otherwise.
wb_sel  out  1  mem_to_reg forwarded during WB, 0 otherwise.
busy  out  1  high in every state except IDLE and ERR.
done  out  1  one-cycle pulse in an instruction's final cycle.
err  out  1  sticky trap flag; high while in ERR.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: state=IDLE, wait counter=0, retired=0. Every output is 0.
  - Reset mid-instruction aborts the instruction without a retire or done.
  - Reset is the only exit from ERR.
- All outputs are combinational decodes of the state register plus the current inputs. There are no output registers.
- IDLE: run=1 goes to FETCH next cycle; otherwise stay.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr_sel=0.
  - When mem_ready=1: ir_write=1, pc_inc=1 in that same cycle, next state DECODE.
- DECODE: one idle cycle so the decoder can register the control word; next state EXEC.
- EXEC: alu_en=1, alu_op_out=alu_op. Transition depends on the control word:
  - mem_read=1 and mem_write=1: illegal; go to ERR with no strobes beyond alu_en.
  - branch=1: pc_branch=alu_zero, done=1, end of instruction.
  - mem_read or mem_write: go to MEM.
  - reg_write: go to WB.
  - Otherwise (all-zero word, i.e. unknown opcode): NOP; done=1, end of instruction.
- MEM:
  - Drives mem_req=1, mem_addr_sel=1, mem_we=mem_write.
  - On mem_ready=1: a load (mem_read) goes to WB; a store sets done=1 and ends the instruction.
- WB: rf_we=1, rf_dst_sel=reg_dst, wb_sel=mem_to_reg, done=1, end of instruction.
- End of instruction: retired increments by 1 and wraps at 2^CNT_W−1 → 0. Next state is FETCH if run=1, else IDLE. Deasserting run never truncates an in-flight instruction.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle in those states with mem_ready=0.
  - If it reaches TIMEOUT with mem_ready still 0, go to ERR; no ir_write and no retire.
  - mem_ready=1 in the same cycle the count hits TIMEOUT counts as success: ready wins.
- ERR: err=1, busy=0, all strobes 0, retired frozen.
- Minimum latency with zero-wait memory, FETCH to done:
  - R-type 4 cycles, lw 5, sw 4, beq 3, NOP 3.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset then run=1, R-type word (reg_dst=1, reg_write=1, alu_op=10), mem_ready tied 1 → ir_write in cycle 1, alu_en with alu_op_out=10 in cycle 3, rf_we=rf_dst_sel=1 plus done in cycle 4; retired=1; next cycle is FETCH.
- lw word with mem_ready low for 3 MEM cycles → mem_req/mem_addr_sel=1/mem_we=0 held 4 cycles; WB with wb_sel=1, rf_we=1; 8 cycles total.
- beq with alu_zero=1, then beq with alu_zero=0 → pc_branch=1 in the first EXEC only; both pulse done in cycle 3; retired=2.
- sw word with run dropped during MEM → mem_we=1, done pulses, then IDLE with busy=0; no further mem_req.
- TIMEOUT=4, mem_ready held 0 in FETCH → err=1 after 4 wait cycles, all strobes 0, retired unchanged. Separate run with mem_ready=1 exactly on the 4th wait cycle → succeeds. rst=1 → IDLE, err=0.
- Control word with mem_read=mem_write=1 → ERR after EXEC, no mem_req. All-zero word → NOP retire in 3 cycles. CNT_W=2 after 4 retirements → retired=0.
